// File: rtl/fetch_fifo_if.sv
// rtl/fetch_fifo_if.sv - fetch-to-decode buffer handshake bundle
interface fetch_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid_i;
    logic [31:0]   in_instr_i;
    logic [31:0]   in_addr_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [31:0]   out_instr_o;
    logic [31:0]   out_addr_o;
    logic          out_ready_i;
    logic          flush_i;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    modport master (
        output in_valid_i, in_instr_i, in_addr_i, out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_addr_o, count_o, overflow_o
    );

    modport slave (
        input  in_valid_i, in_instr_i, in_addr_i, out_ready_i, flush_i,
        output in_ready_o, out_valid_o, out_instr_o, out_addr_o, count_o, overflow_o
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction decoupling FIFO between fetch and decode
module fetch_fifo #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop;
    logic [63:0]   head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Ready/valid depend only on registered count: no in->out or ready->ready comb paths
    assign push  = bus.in_valid_i & ~full & ~bus.flush_i;
    assign pop   = ~empty & bus.out_ready_i & ~bus.flush_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.in_valid_i & full & ~bus.flush_i);
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never reset; count alone decides which entries are live
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_addr_i, bus.in_instr_i};
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.in_ready_o  = ~full;
    assign bus.out_valid_o = ~empty;
    assign bus.out_instr_o = empty ? NOP_INSTR : head[31:0];
    assign bus.out_addr_o  = empty ? 32'h0 : head[63:32];
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_fetch_fifo.sv
// tb/tb_fetch_fifo.sv - self-checking bench for fetch_fifo
module tb_fetch_fifo;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_fifo_if #(.DEPTH(DEPTH)) bus ();
    fetch_fifo #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: entries are {addr, instr}
    logic [63:0] mq[$];
    bit          movf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            movf = 1'b0;
        end else if (bus.flush_i) begin
            mq.delete();
        end else begin
            bit was_full, do_pop;
            was_full = (mq.size() == DEPTH);
            do_pop   = (mq.size() != 0) && bus.out_ready_i;
            if (bus.in_valid_i && was_full) movf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (bus.in_valid_i && !was_full) mq.push_back({bus.in_addr_i, bus.in_instr_i});
        end
    end

    always @(negedge clk) begin
        bit e_valid;
        e_valid = (mq.size() != 0);
        chk("m_out_valid", 64'(bus.out_valid_o), 64'(e_valid));
        chk("m_in_ready",  64'(bus.in_ready_o),  64'(mq.size() != DEPTH));
        chk("m_count",     64'(bus.count_o),     64'(mq.size()));
        chk("m_overflow",  64'(bus.overflow_o),  64'(movf));
        chk("m_out_instr", 64'(bus.out_instr_o), e_valid ? 64'(mq[0][31:0]) : 64'(NOP));
        chk("m_out_addr",  64'(bus.out_addr_o),  e_valid ? 64'(mq[0][63:32]) : 64'h0);
    end

    task automatic step(input bit v, input logic [31:0] a, input bit r, input bit f);
        bus.in_valid_i  = v;
        bus.in_addr_i   = a;
        bus.in_instr_i  = a ^ 32'hC0DE_0000;
        bus.out_ready_i = r;
        bus.flush_i     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid_i = 0; bus.in_addr_i = 0; bus.in_instr_i = 0;
        bus.out_ready_i = 0; bus.flush_i = 0;
        #1;
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_instr", 64'(bus.out_instr_o), 64'(NOP));
        chk("rst_addr", 64'(bus.out_addr_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0, 0);

        // Fill and drain
        for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0);
        chk("fill_count", 64'(bus.count_o), 64'd4);
        chk("fill_in_ready", 64'(bus.in_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 64'(bus.out_addr_o), 64'(i * 4));
            chk("drain_instr", 64'(bus.out_instr_o), 64'(32'(i * 4) ^ 32'hC0DE_0000));
            step(0, 0, 1, 0);
        end
        chk("drain_empty", 64'(bus.out_valid_o), 64'd0);
        chk("drain_nop", 64'(bus.out_instr_o), 64'(NOP));

        // Streaming with pointer wrap
        for (int k = 0; k < 20; k++) begin
            step(1, 32'h1000 + 32'(k * 4), 1, 0);
            chk("stream_count", 64'(bus.count_o), 64'd1);
            chk("stream_head", 64'(bus.out_addr_o), 64'(32'h1000 + 32'(k * 4)));
        end
        step(0, 0, 1, 0);
        chk("stream_empty", 64'(bus.count_o), 64'd0);
        chk("stream_no_ovf", 64'(bus.overflow_o), 64'd0);

        // Full with simultaneous pop: push refused, overflow set
        for (int i = 0; i < 4; i++) step(1, 32'h40 + 32'(i * 4), 0, 0);
        step(1, 32'h50, 1, 0);
        chk("fullpop_count", 64'(bus.count_o), 64'd3);
        chk("fullpop_ovf", 64'(bus.overflow_o), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk("fullpop_head", 64'(bus.out_addr_o), 64'(32'h40 + 32'(i * 4)));
            step(0, 0, 1, 0);
        end
        chk("fullpop_empty", 64'(bus.out_valid_o), 64'd0);

        // Flush drops buffered words and the word offered alongside it
        for (int i = 0; i < 3; i++) step(1, 32'h80 + 32'(i * 4), 0, 0);
        step(1, 32'h100, 0, 1);
        chk("flush_count", 64'(bus.count_o), 64'd0);
        chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("flush_keeps_ovf", 64'(bus.overflow_o), 64'd1);
        step(1, 32'h200, 0, 0);
        chk("post_flush_head", 64'(bus.out_addr_o), 64'h200);
        chk("post_flush_count", 64'(bus.count_o), 64'd1);
        step(0, 0, 1, 0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i * 4), 0, 0);
        bus.in_valid_i = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 64'(bus.count_o), 64'd0);
        chk("arst_ovf", 64'(bus.overflow_o), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("arst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("arst_instr", 64'(bus.out_instr_o), 64'(NOP));
        chk("arst_addr", 64'(bus.out_addr_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 9) < 7, 32'h4000 + 32'(c * 4),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
